// File: rtl/down_counter4bit.sv
// Loadable 4-bit down counter with IDLE/RUN/DONE control, optional auto-reload
// from the last loaded value, and a registered one-cycle terminal-count pulse.
module down_counter4bit #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] D,
    output logic [3:0] Q,
    output logic       busy,
    output logic       zero,
    output logic       tc
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e     state;
    logic [3:0] rv;

    always_ff @(posedge clk) begin
        if (rst) begin
            Q     <= 4'd0;
            rv    <= 4'd0;
            state <= StIdle;
            tc    <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                // Load wins over everything else, including a pending 1->0 step.
                Q     <= D;
                rv    <= D;
                state <= (D != 4'd0) ? StRun : StDone;
            end else begin
                case (state)
                    StIdle: begin
                    end
                    StRun: begin
                        if (en) begin
                            if (Q > 4'd1) begin
                                Q <= Q - 4'd1;
                            end else begin
                                // Q==0 in RUN is unreachable; retire it without a pulse.
                                Q     <= 4'd0;
                                state <= StDone;
                                tc    <= (Q == 4'd1);
                            end
                        end
                    end
                    StDone: begin
                        if (AUTO_RELOAD && en && (rv != 4'd0)) begin
                            Q     <= rv;
                            state <= StRun;
                        end
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign busy = (state == StRun);
    assign zero = (Q == 4'd0);

    // A terminal-count pulse always lands on a zero count in DONE.
    tc_at_zero_a: assert property (@(posedge clk) disable iff (rst)
        tc |-> (zero && state == StDone));

    // tc never stays high for two consecutive cycles.
    tc_single_a: assert property (@(posedge clk) disable iff (rst) tc |=> !tc);

    generate
        if (!AUTO_RELOAD) begin : g_no_wrap
            // Without reload the only way out of zero is a load.
            no_wrap_a: assert property (@(posedge clk) disable iff (rst)
                (zero && !load) |=> zero);
        end
    endgenerate

endmodule

// File: tb/tb_down_counter4bit.sv
// Scoreboard bench for down_counter4bit: one instance per AUTO_RELOAD setting,
// expectations queued as each stimulus row is driven and checked after the edge.
module tb_down_counter4bit;

    typedef struct packed {
        logic [3:0] q;
        logic       tc;
        logic       busy;
        logic       zero;
    } obs_t;

    typedef struct packed {
        logic sel;
        obs_t exp;
    } sb_t;

    typedef struct packed {
        logic       r;
        logic       l;
        logic       e;
        logic [3:0] d;
        logic [3:0] q;
        logic       t;
        logic       b;
    } row_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] D;
    logic [3:0] q0, q1;
    logic       busy0, busy1, zero0, zero1, tc0, tc1;
    obs_t       obs0, obs1;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    down_counter4bit #(.AUTO_RELOAD(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .load(load),
        .D   (D),
        .Q   (q0),
        .busy(busy0),
        .zero(zero0),
        .tc  (tc0)
    );

    down_counter4bit #(.AUTO_RELOAD(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .load(load),
        .D   (D),
        .Q   (q1),
        .busy(busy1),
        .zero(zero1),
        .tc  (tc1)
    );

    assign obs0 = {q0, tc0, busy0, zero0};
    assign obs1 = {q1, tc1, busy1, zero1};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic row_t row(input logic r, input logic l, input logic e,
                                 input logic [3:0] d, input logic [3:0] q,
                                 input logic t, input logic b);
        row = {r, l, e, d, q, t, b};
    endfunction

    function automatic string fmt(input obs_t o);
        fmt = $sformatf("q=%0d tc=%b busy=%b zero=%b", o.q, o.tc, o.busy, o.zero);
    endfunction

    // Drive one row, queue what the selected instance must show after the edge.
    task automatic apply(input row_t rw, input logic sel);
        obs_t exp;
        rst  = rw.r;
        load = rw.l;
        en   = rw.e;
        D    = rw.d;
        exp  = {rw.q, rw.t, rw.b, (rw.q == 4'd0)};
        sb_q.push_back({sel, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        sb_t  ent;
        obs_t got;
        rows = '{row(1, 1, 1, 9, 0, 0, 0), row(1, 1, 1, 9, 0, 0, 0),
                 row(0, 0, 1, 9, 0, 0, 0), row(0, 0, 1, 9, 0, 0, 0),
                 row(0, 0, 1, 9, 0, 0, 0)};
        foreach (rows[i]) begin
            apply(rows[i], 1'b0);
            ent = sb_q.pop_front();
            got = ent.sel ? obs1 : obs0;
            checks++;
            if (got !== ent.exp) begin
                errors++;
                $display("FAIL reset[%0d]: got %s want %s", i, fmt(got), fmt(ent.exp));
            end
        end
    endtask

    task automatic test_basic_count();
        row_t rows[$];
        sb_t  ent;
        obs_t got;
        rows = '{row(0, 1, 0, 3, 3, 0, 1), row(0, 0, 1, 0, 2, 0, 1),
                 row(0, 0, 1, 0, 1, 0, 1), row(0, 0, 1, 0, 0, 1, 0)};
        for (int k = 0; k < 5; k++) rows.push_back(row(0, 0, 1, 0, 0, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i], 1'b0);
            ent = sb_q.pop_front();
            got = ent.sel ? obs1 : obs0;
            checks++;
            if (got !== ent.exp) begin
                errors++;
                $display("FAIL basic[%0d]: got %s want %s", i, fmt(got), fmt(ent.exp));
            end
        end
    endtask

    task automatic test_enable_gating();
        row_t rows[$];
        sb_t  ent;
        obs_t got;
        rows = '{row(0, 1, 0, 5, 5, 0, 1), row(0, 0, 1, 0, 4, 0, 1),
                 row(0, 0, 0, 0, 4, 0, 1), row(0, 0, 0, 0, 4, 0, 1),
                 row(0, 0, 1, 0, 3, 0, 1), row(0, 0, 1, 0, 2, 0, 1)};
        foreach (rows[i]) begin
            apply(rows[i], 1'b0);
            ent = sb_q.pop_front();
            got = ent.sel ? obs1 : obs0;
            checks++;
            if (got !== ent.exp) begin
                errors++;
                $display("FAIL gating[%0d]: got %s want %s", i, fmt(got), fmt(ent.exp));
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        sb_t  ent;
        obs_t got;
        // Load collides with the 1->0 step: the load wins and no pulse appears.
        rows = '{row(0, 1, 0, 1, 1, 0, 1), row(0, 1, 1, 7, 7, 0, 1),
                 row(0, 0, 1, 0, 6, 0, 1), row(0, 1, 1, 0, 0, 0, 0),
                 row(0, 0, 1, 0, 0, 0, 0)};
        foreach (rows[i]) begin
            apply(rows[i], 1'b0);
            ent = sb_q.pop_front();
            got = ent.sel ? obs1 : obs0;
            checks++;
            if (got !== ent.exp) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %s want %s", i, fmt(got), fmt(ent.exp));
            end
        end
    endtask

    task automatic test_auto_reload();
        row_t rows[$];
        sb_t  ent;
        obs_t got;
        rows = '{row(0, 1, 0, 2, 2, 0, 1), row(0, 0, 1, 0, 1, 0, 1),
                 row(0, 0, 1, 0, 0, 1, 0), row(0, 0, 1, 0, 2, 0, 1),
                 row(0, 0, 1, 0, 1, 0, 1), row(0, 0, 1, 0, 0, 1, 0),
                 row(0, 0, 0, 0, 0, 0, 0), row(0, 0, 0, 0, 0, 0, 0),
                 row(0, 0, 1, 0, 2, 0, 1)};
        foreach (rows[i]) begin
            apply(rows[i], 1'b1);
            ent = sb_q.pop_front();
            got = ent.sel ? obs1 : obs0;
            checks++;
            if (got !== ent.exp) begin
                errors++;
                $display("FAIL auto_reload[%0d]: got %s want %s", i, fmt(got), fmt(ent.exp));
            end
        end
    endtask

    task automatic test_zero_load();
        row_t rows[$];
        sb_t  ent;
        obs_t got;
        // Reload value of zero keeps the auto-reload instance parked in DONE.
        rows = '{row(0, 1, 1, 0, 0, 0, 0), row(0, 0, 1, 0, 0, 0, 0),
                 row(0, 0, 1, 0, 0, 0, 0)};
        foreach (rows[i]) begin
            apply(rows[i], 1'b1);
            ent = sb_q.pop_front();
            got = ent.sel ? obs1 : obs0;
            checks++;
            if (got !== ent.exp) begin
                errors++;
                $display("FAIL zero_load[%0d]: got %s want %s", i, fmt(got), fmt(ent.exp));
            end
        end
    endtask

    task automatic test_mid_count_reset();
        row_t rows[$];
        sb_t  ent;
        obs_t got;
        rows = '{row(0, 1, 0, 15, 15, 0, 1), row(0, 0, 1, 0, 14, 0, 1),
                 row(0, 0, 1, 0, 13, 0, 1), row(0, 0, 1, 0, 12, 0, 1),
                 row(0, 0, 1, 0, 11, 0, 1), row(0, 0, 1, 0, 10, 0, 1),
                 row(1, 0, 1, 0, 0, 0, 0), row(0, 0, 1, 0, 0, 0, 0),
                 row(0, 0, 1, 0, 0, 0, 0)};
        foreach (rows[i]) begin
            apply(rows[i], 1'b0);
            ent = sb_q.pop_front();
            got = ent.sel ? obs1 : obs0;
            checks++;
            if (got !== ent.exp) begin
                errors++;
                $display("FAIL mid_reset[%0d]: got %s want %s", i, fmt(got), fmt(ent.exp));
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        en   = 1'b0;
        D    = 4'd0;
        test_reset();
        test_basic_count();
        test_enable_gating();
        test_back_to_back();
        test_auto_reload();
        test_zero_load();
        test_mid_count_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/down_counter4bit.md
DOWN_COUNTER4BIT -- requirements
Module: down_counter4bit

Interface
REQ-001 The block SHALL have the parameter AUTO_RELOAD, default 0: when 1, the block reloads from the stored load value on reaching zero; when 0, it stops at zero.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port en, input, 1 bit: count enable; when high, allows one decrement per cycle.
REQ-005 The block SHALL have port load, input, 1 bit: load strobe; when high, captures D.
REQ-006 The block SHALL have port D, input, 4 bits: load value, unsigned.
REQ-007 The block SHALL have port Q, output, 4 bits: current count, registered.
REQ-008 The block SHALL have port busy, output, 1 bit: high while the FSM is in RUN.
REQ-009 The block SHALL have port zero, output, 1 bit: combinational (Q == 4'd0).
REQ-010 The block SHALL have port tc, output, 1 bit: terminal-count pulse, registered, one cycle wide.

Function
REQ-011 The block SHALL implement the FSM states IDLE, RUN and DONE, plus a 4-bit reload register RV.
REQ-012 In all states, load SHALL take priority over en: load=1 SHALL set Q<=D and RV<=D, and SHALL set the next state to RUN if D!=0, otherwise DONE.
REQ-013 A load SHALL NOT assert tc, including a load of D=0.
REQ-014 In IDLE with load=0, Q SHALL hold and en SHALL be ignored.
REQ-015 In RUN with en=1 and Q>1, the block SHALL set Q<=Q-1 and remain in RUN.
REQ-016 In RUN with en=1 and Q==1, the block SHALL set Q<=0, set the next state to DONE, and assert tc=1 in the same cycle Q first reads 0 (single-cycle latency from the enabling edge).
REQ-017 In RUN with en=0, Q and the state SHALL hold.
REQ-018 In DONE with AUTO_RELOAD=0, Q SHALL hold at 0 regardless of en; no underflow wrap from 0 to 15 SHALL ever occur.
REQ-019 In DONE with AUTO_RELOAD=1 and en=1, the block SHALL set Q<=RV and go to RUN if RV!=0; if RV==0, it SHALL remain in DONE with Q=0.
REQ-020 In DONE with AUTO_RELOAD=1 and en=0, the block SHALL hold.
REQ-021 tc SHALL be high for exactly one cycle per 1->0 decrement and low in all other cycles.
REQ-022 Back-to-back events SHALL be handled as follows: load in the same cycle as the 1->0 decrement SHALL win, with no tc and Q=D.
REQ-023 busy SHALL be decoded from the state register only, so that busy=1 exactly when state==RUN.
REQ-024 All arithmetic SHALL be unsigned 4-bit with no carry or borrow output.

Reset
REQ-025 When rst=1 at a rising clk edge, the block SHALL set Q=4'b0000, RV=4'b0000, state=IDLE, tc=0 and busy=0; zero SHALL therefore read 1.
REQ-026 rst SHALL have priority over load and en in every state, including mid-count in RUN.
REQ-027 The first cycle after rst deasserts SHALL behave as IDLE.

Verification
REQ-028 Reset: assert rst 2 cycles with load=1, D=9 and en=1 -> Q=0, zero=1, busy=0, tc=0; after release the block is in IDLE and Q holds 0 while en=1.
REQ-029 Basic count: load D=3, then en=1 continuously -> Q sequence 3,2,1,0; tc=1 only in the cycle Q=0; busy 1,1,1,0; Q then stays 0 for 5 further cycles (AUTO_RELOAD=0).
REQ-030 Enable gating: load D=5 and toggle en 1,0,0,1,1 -> Q sequence 5,4,4,4,3,2; no tc.
REQ-031 Load priority: with Q=1 in RUN, apply load=1, D=7 and en=1 in the same cycle -> Q=7, tc=0, busy=1.
REQ-032 Auto-reload: with AUTO_RELOAD=1, load D=2 and hold en=1 -> Q sequence 2,1,0,2,1,0; tc=1 at each 0; period 3 cycles.
REQ-033 Zero load and mid-count reset: load D=0 -> state DONE, Q=0, tc=0, busy=0; separately, load D=15, count to 10, assert rst -> Q=0 and busy=0 on the next edge.
